// File: rtl/demux_1_to_n_hs_if.sv
// Handshake bundle for the 1-to-N operand demultiplexer: one valid/ready input
// port, NUM_OUT valid/ready output channels and the sticky select-error flag.
// master drives the input word and the output-side readies; slave is the demux.
//   in_data/in_sel/in_bcast/in_valid -> word, channel index, broadcast, valid
//   in_ready                         <- demux can take the word this cycle
//   out_data/out_valid               <- channel i at [i*WIDTH +: WIDTH]
//   out_ready                        -> channel i consumer takes its word
//   sel_err / err_clr                <- sticky bad-index flag / its clear
interface demux_1_to_n_hs_if #(
    parameter int WIDTH   = 16,
    parameter int NUM_OUT = 8
);
    localparam int SEL_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    logic [WIDTH-1:0]         in_data;
    logic [SEL_W-1:0]         in_sel;
    logic                     in_bcast;
    logic                     in_valid;
    logic                     in_ready;
    logic [NUM_OUT*WIDTH-1:0] out_data;
    logic [NUM_OUT-1:0]       out_valid;
    logic [NUM_OUT-1:0]       out_ready;
    logic                     sel_err;
    logic                     err_clr;

    modport master (
        output in_data, in_sel, in_bcast, in_valid, out_ready, err_clr,
        input  in_ready, out_data, out_valid, sel_err
    );

    modport slave (
        input  in_data, in_sel, in_bcast, in_valid, out_ready, err_clr,
        output in_ready, out_data, out_valid, sel_err
    );
endinterface

// File: rtl/demux_1_to_n_hs.sv
// Routes one operand word to a selected channel or broadcasts it to all, each channel a one-entry register.
// Latency: word accepted on edge k is visible with out_valid=1 right after edge k; 1 word/clk per channel.
// Backpressure: in_ready drops when the target channel (or any channel, for broadcast) is full and not draining.
// Ports: clk, rst (synchronous, active-high); bus = demux_1_to_n_hs_if.slave
//   (input word/sel/bcast/valid/ready, per-channel data/valid/ready, sel_err/err_clr).
module demux_1_to_n_hs #(
    parameter int WIDTH     = 16,
    parameter int NUM_OUT   = 8,
    parameter int ZERO_IDLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    demux_1_to_n_hs_if.slave   bus
);
    localparam int SEL_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam int SEL_N = 1 << SEL_W;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] sel;
        logic             bcast;
    } req_t;

    req_t               req;
    logic [WIDTH-1:0]   data_q [NUM_OUT];
    logic [NUM_OUT-1:0] valid_q;
    logic               err_q;

    // can_load is padded to the full index range so in_sel never reads past it.
    logic [SEL_N-1:0]   can_load;
    logic [NUM_OUT-1:0] hit;
    logic               sel_ok;
    logic               ready;
    logic               accept;

    assign req = '{data: bus.in_data, sel: bus.in_sel, bcast: bus.in_bcast};

    always_comb begin
        can_load = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            can_load[i] = !valid_q[i] || bus.out_ready[i];
        end
    end

    assign sel_ok = int'(req.sel) < NUM_OUT;

    // No term here looks at in_valid, so a source may wait for in_ready first.
    always_comb begin
        ready = 1'b0;
        if (rst) begin
            ready = 1'b0;
        end else if (req.bcast) begin
            ready = &can_load[NUM_OUT-1:0];
        end else if (!sel_ok) begin
            ready = 1'b1;
        end else begin
            ready = can_load[req.sel];
        end
    end

    assign accept = bus.in_valid && ready;

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            hit[i] = accept && (req.bcast || (sel_ok && (req.sel == SEL_W'(i))));
        end
    end

    // A load replaces a word that drains on the same edge, so a channel with
    // its consumer ready streams one word per clock without bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < NUM_OUT; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (hit[i]) begin
                    data_q[i]  <= req.data;
                    valid_q[i] <= 1'b1;
                end else if (valid_q[i] && bus.out_ready[i]) begin
                    valid_q[i] <= 1'b0;
                    if (ZERO_IDLE != 0) begin
                        data_q[i] <= '0;
                    end
                end
            end
        end
    end

    // A new bad-index accept outranks a clear on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept && !req.bcast && !sel_ok) begin
            err_q <= 1'b1;
        end else if (bus.err_clr) begin
            err_q <= 1'b0;
        end
    end

    always_comb begin
        bus.out_data = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            bus.out_data[i*WIDTH +: WIDTH] = data_q[i];
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = valid_q;
    assign bus.sel_err   = err_q;
endmodule

// File: tb/tb_demux_1_to_n_hs.sv
// Bench for demux_1_to_n_hs: two instances (8 channels zero-idle, 5 channels hold-last)
// share one stimulus stream; a per-channel occupancy model tracks both.
// Directed table rows, hand sequences for bad index / hold-last, then random traffic.
module tb_demux_1_to_n_hs;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    demux_1_to_n_hs_if #(.WIDTH(16), .NUM_OUT(8)) ifa ();
    demux_1_to_n_hs_if #(.WIDTH(16), .NUM_OUT(5)) ifb ();

    demux_1_to_n_hs #(.WIDTH(16), .NUM_OUT(8), .ZERO_IDLE(1)) u_a (.clk(clk), .rst(rst), .bus(ifa));
    demux_1_to_n_hs #(.WIDTH(16), .NUM_OUT(5), .ZERO_IDLE(0)) u_b (.clk(clk), .rst(rst), .bus(ifb));

    int vectors     = 0;
    int miscompares = 0;

    // Current stimulus, as driven to both instances.
    logic        c_rst, c_vld, c_bc, c_clr;
    logic [2:0]  c_sel;
    logic [15:0] c_dat;
    logic [7:0]  c_ordy;

    // Model: each channel is either empty or holding one word.
    bit          m_full [2][8];
    logic [15:0] m_word [2][8];
    bit          m_err  [2];
    bit          m_live = 1'b0;
    int          m_n    [2] = '{8, 5};
    bit          m_zi   [2] = '{1'b1, 1'b0};

    typedef struct {
        logic        r, v, b;
        logic [2:0]  s;
        logic [15:0] d;
        logic [7:0]  o;
        logic        c;
        logic        e_rdy;
        logic [7:0]  e_vld;
        int          e_ch;
        logic [15:0] e_dat;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input logic r, input logic v, input logic b, input logic [2:0] s,
                         input logic [15:0] d, input logic [7:0] o, input logic c);
        c_rst = r; c_vld = v; c_bc = b; c_sel = s; c_dat = d; c_ordy = o; c_clr = c;
        rst = r;
        ifa.in_valid = v; ifa.in_bcast = b; ifa.in_sel = s; ifa.in_data = d;
        ifa.out_ready = o; ifa.err_clr = c;
        ifb.in_valid = v; ifb.in_bcast = b; ifb.in_sel = s; ifb.in_data = d;
        ifb.out_ready = o[4:0]; ifb.err_clr = c;
    endtask

    function automatic bit m_rdy(int u);
        if (c_rst) return 1'b0;
        if (c_bc) begin
            for (int k = 0; k < m_n[u]; k++)
                if (m_full[u][k] && !c_ordy[k]) return 1'b0;
            return 1'b1;
        end
        if (int'(c_sel) >= m_n[u]) return 1'b1;
        return !m_full[u][c_sel] || c_ordy[c_sel];
    endfunction

    task automatic model_check();
        logic [7:0]   ev;
        logic [127:0] ed;
        if (!m_live) return;
        for (int u = 0; u < 2; u++) begin
            ev = '0;
            ed = '0;
            for (int k = 0; k < m_n[u]; k++) begin
                ev[k]          = m_full[u][k];
                ed[k*16 +: 16] = m_word[u][k];
            end
            if (u == 0) begin
                chk("a_in_ready",  128'(ifa.in_ready),  128'(m_rdy(0)));
                chk("a_out_valid", 128'(ifa.out_valid), 128'(ev));
                chk("a_out_data",  128'(ifa.out_data),  ed);
                chk("a_sel_err",   128'(ifa.sel_err),   128'(m_err[0]));
            end else begin
                chk("b_in_ready",  128'(ifb.in_ready),  128'(m_rdy(1)));
                chk("b_out_valid", 128'(ifb.out_valid), 128'(ev));
                chk("b_out_data",  128'(ifb.out_data),  ed);
                chk("b_sel_err",   128'(ifb.sel_err),   128'(m_err[1]));
            end
        end
    endtask

    task automatic model_update();
        bit acc;
        for (int u = 0; u < 2; u++) begin
            if (c_rst) begin
                for (int k = 0; k < 8; k++) begin
                    m_full[u][k] = 1'b0;
                    m_word[u][k] = '0;
                end
                m_err[u] = 1'b0;
            end else begin
                acc = c_vld && m_rdy(u);
                for (int k = 0; k < m_n[u]; k++) begin
                    if (acc && (c_bc || int'(c_sel) == k)) begin
                        m_full[u][k] = 1'b1;
                        m_word[u][k] = c_dat;
                    end else if (m_full[u][k] && c_ordy[k]) begin
                        m_full[u][k] = 1'b0;
                        if (m_zi[u]) m_word[u][k] = '0;
                    end
                end
                if (acc && !c_bc && int'(c_sel) >= m_n[u]) m_err[u] = 1'b1;
                else if (c_clr) m_err[u] = 1'b0;
            end
        end
        if (c_rst) m_live = 1'b1;
    endtask

    task automatic pre();
        #1;
        model_check();
    endtask

    task automatic post();
        model_update();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          r  v  b  s  d         o      c  rdy vld    ch dat
        tbl[0]  = '{1, 1, 0, 3, 16'h5555, 8'hFF, 0, 0, 8'h00, 3, 16'h0000};
        tbl[1]  = '{1, 1, 0, 3, 16'h5555, 8'hFF, 0, 0, 8'h00, 3, 16'h0000};
        tbl[2]  = '{0, 1, 0, 3, 16'hA5A5, 8'hFF, 0, 1, 8'h08, 3, 16'hA5A5};
        tbl[3]  = '{0, 1, 0, 7, 16'h1234, 8'hFF, 0, 1, 8'h80, 7, 16'h1234};
        tbl[4]  = '{0, 0, 0, 0, 16'h0000, 8'hFF, 0, 1, 8'h00, 7, 16'h0000};
        tbl[5]  = '{0, 1, 0, 2, 16'h0001, 8'hFB, 0, 1, 8'h04, 2, 16'h0001};
        tbl[6]  = '{0, 1, 0, 2, 16'h0002, 8'hFB, 0, 0, 8'h04, 2, 16'h0001};
        tbl[7]  = '{0, 1, 0, 5, 16'h0003, 8'hFB, 0, 1, 8'h24, 5, 16'h0003};
        tbl[8]  = '{0, 1, 0, 2, 16'h0002, 8'hFF, 0, 1, 8'h04, 2, 16'h0002};
        tbl[9]  = '{0, 1, 0, 6, 16'h1111, 8'hBF, 0, 1, 8'h40, 6, 16'h1111};
        tbl[10] = '{0, 1, 1, 0, 16'hBEEF, 8'hBF, 0, 0, 8'h40, 6, 16'h1111};
        tbl[11] = '{0, 1, 1, 0, 16'hBEEF, 8'hFF, 0, 1, 8'hFF, 0, 16'hBEEF};
        tbl[12] = '{0, 0, 0, 0, 16'h0000, 8'h00, 0, 0, 8'hFF, 6, 16'hBEEF};
        tbl[13] = '{0, 0, 0, 0, 16'h0000, 8'hFF, 0, 1, 8'h00, 6, 16'h0000};
        tbl[14] = '{0, 1, 0, 4, 16'h4444, 8'h00, 0, 1, 8'h10, 4, 16'h4444};
        tbl[15] = '{1, 1, 0, 1, 16'h9999, 8'h00, 0, 0, 8'h00, 4, 16'h0000};
        tbl[16] = '{0, 0, 0, 0, 16'h0000, 8'hFF, 0, 1, 8'h00, 0, 16'h0000};

        for (int i = 0; i < 17; i++) begin
            apply(tbl[i].r, tbl[i].v, tbl[i].b, tbl[i].s, tbl[i].d, tbl[i].o, tbl[i].c);
            pre();
            chk($sformatf("row%0d_in_ready", i), 128'(ifa.in_ready), 128'(tbl[i].e_rdy));
            post();
            chk($sformatf("row%0d_out_valid", i), 128'(ifa.out_valid), 128'(tbl[i].e_vld));
            chk($sformatf("row%0d_ch%0d_data", i, tbl[i].e_ch),
                128'(ifa.out_data[tbl[i].e_ch*16 +: 16]), 128'(tbl[i].e_dat));
            @(negedge clk);
        end

        // Bad index on the 5-channel instance, set-over-clear, hold-last drain.
        apply(1, 0, 0, 0, 16'h0000, 8'hFF, 0);
        pre(); post(); @(negedge clk);

        apply(0, 1, 0, 6, 16'hDEAD, 8'hFF, 0);
        pre();
        chk("b_bad_sel_ready", 128'(ifb.in_ready), 128'(1'b1));
        post();
        chk("b_bad_sel_valid", 128'(ifb.out_valid), 128'(5'h00));
        chk("b_bad_sel_err", 128'(ifb.sel_err), 128'(1'b1));
        @(negedge clk);

        apply(0, 1, 0, 1, 16'h7777, 8'h00, 0);
        pre(); post();
        chk("b_load_valid", 128'(ifb.out_valid), 128'(5'h02));
        chk("b_load_ch1", 128'(ifb.out_data[16 +: 16]), 128'(16'h7777));
        @(negedge clk);

        apply(0, 1, 0, 7, 16'h0BAD, 8'h00, 1);
        pre();
        chk("b_bad_clr_ready", 128'(ifb.in_ready), 128'(1'b1));
        post();
        chk("b_set_beats_clr", 128'(ifb.sel_err), 128'(1'b1));
        chk("b_stall_valid", 128'(ifb.out_valid), 128'(5'h02));
        @(negedge clk);

        apply(0, 0, 0, 0, 16'h0000, 8'hFF, 1);
        pre(); post();
        chk("b_clr_alone", 128'(ifb.sel_err), 128'(1'b0));
        chk("b_drain_valid", 128'(ifb.out_valid), 128'(5'h00));
        chk("b_hold_last_ch1", 128'(ifb.out_data[16 +: 16]), 128'(16'h7777));
        chk("a_zero_idle_ch1", 128'(ifa.out_data[16 +: 16]), 128'(16'h0000));
        @(negedge clk);

        for (int n = 0; n < 3000; n++) begin
            apply(1'($urandom_range(0, 63) == 0),
                  1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 7) == 0),
                  3'($urandom),
                  16'($urandom),
                  8'($urandom) | 8'($urandom),
                  1'($urandom_range(0, 7) == 0));
            pre(); post();
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
